// File: rtl/uart_ram_loader_if.sv
// uart_ram_loader_if: serial input, load request and RAM write/status bus of the loader
interface uart_ram_loader_if #(
  parameter int ADDR_W = 16
);
  logic              rx;
  logic              load_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              busy;
  logic              done;
  logic              frame_err;
  logic [7:0]        byte_cnt_led;
  modport master (
    input  rx, load_en,
    output ram_we, ram_addr, ram_din, busy, done, frame_err, byte_cnt_led
  );
  modport slave (
    output rx, load_en,
    input  ram_we, ram_addr, ram_din, busy, done, frame_err, byte_cnt_led
  );
endinterface

// File: rtl/uart_ram_loader.sv
// uart_ram_loader: 8N1 UART receiver that writes one image frame of bytes into RAM
module uart_ram_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMG_BYTES    = 65536,
  parameter int ADDR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_ram_loader_if.master bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(IMG_BYTES - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_st_t;
  rx_st_t rx_st_q, rx_st_d;
  ld_st_t ld_st_q, ld_st_d;
  logic [1:0]    sync_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shf_q, shf_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic we_q, we_d, ferr_q, ferr_d;
  logic rx_s, bit_end, stop_smp, last_wr;
  assign rx_s     = sync_q[1];
  assign bit_end  = tmr_q == FULL;
  assign stop_smp = rx_st_q == RX_STOP && bit_end;
  assign last_wr  = we_q && cnt_q == LAST;
  always_comb begin
    rx_st_d = rx_st_q;
    tmr_d   = tmr_q + 1'b1;
    idx_d   = idx_q;
    shf_d   = shf_q;
    case (rx_st_q)
      RX_IDLE: begin
        tmr_d   = '0;
        rx_st_d = rx_s ? RX_IDLE : RX_START;
      end
      RX_START: if (tmr_q == HALF) begin
        rx_st_d = rx_s ? RX_IDLE : RX_DATA;
        tmr_d   = '0;
        idx_d   = '0;
      end
      RX_DATA: if (bit_end) begin
        tmr_d   = '0;
        shf_d   = {rx_s, shf_q[7:1]};
        idx_d   = idx_q + 1'b1;
        rx_st_d = idx_q == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (bit_end) begin
        tmr_d   = '0;
        rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end
  // the strobe is registered off the stop sample, so it lands one cycle later
  always_comb begin
    ld_st_d = ld_st_q;
    cnt_d   = we_q ? cnt_q + 1'b1 : cnt_q;
    ferr_d  = ferr_q;
    we_d    = 1'b0;
    case (ld_st_q)
      IDLE: if (bus.load_en) begin
        ld_st_d = LOAD;
        cnt_d   = '0;
        ferr_d  = 1'b0;
      end
      LOAD: begin
        ld_st_d = !bus.load_en ? IDLE : last_wr ? DONE : LOAD;
        we_d    = bus.load_en && !last_wr && stop_smp && rx_s;
      end
      DONE: ld_st_d = bus.load_en ? DONE : IDLE;
      default: ld_st_d = IDLE;
    endcase
    ferr_d = (stop_smp && !rx_s) ? 1'b1 : ferr_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      rx_st_q <= RX_IDLE;
      ld_st_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shf_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.rx};
      rx_st_q <= rx_st_d;
      ld_st_q <= ld_st_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shf_q   <= shf_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ferr_q  <= ferr_d;
    end
  end
  assign bus.ram_we       = we_q;
  assign bus.ram_addr     = cnt_q[ADDR_W-1:0];
  assign bus.ram_din      = shf_q;
  assign bus.busy         = ld_st_q == LOAD;
  assign bus.done         = ld_st_q == DONE;
  assign bus.frame_err    = ferr_q;
  assign bus.byte_cnt_led = cnt_q[ADDR_W-1:ADDR_W-8];
endmodule

// File: tb/tb_uart_ram_loader.sv
// tb_uart_ram_loader: directed checks of the UART frame loader with 16 clocks per bit, 4-byte frames
module tb_uart_ram_loader;
  logic clk;
  logic reset;
  int n_chk;
  int n_fail;
  int dbl;
  logic prev_we;
  logic [15:0] wa[$];
  logic [7:0] wd[$];
  uart_ram_loader_if #(.ADDR_W(16)) bus();
  uart_ram_loader #(.CLKS_PER_BIT(16), .IMG_BYTES(4), .ADDR_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    dbl = 0;
    prev_we = 1'b0;
  end
  always @(negedge clk) begin
    if (bus.ram_we) begin
      wa.push_back(bus.ram_addr);
      wd.push_back(bus.ram_din);
      if (prev_we) dbl++;
    end
    prev_we = bus.ram_we;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic chk_wr(input int i, input logic [15:0] a, input logic [7:0] d);
    check($sformatf("wr%0d_addr", i), 32'(wa[i]), 32'(a));
    check($sformatf("wr%0d_data", i), 32'(wd[i]), 32'(d));
  endtask
  task automatic chk_reset_outs(input string tag);
    check({tag, "_we"}, 32'(bus.ram_we), 0);
    check({tag, "_addr"}, 32'(bus.ram_addr), 0);
    check({tag, "_din"}, 32'(bus.ram_din), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_ferr"}, 32'(bus.frame_err), 0);
    check({tag, "_led"}, 32'(bus.byte_cnt_led), 0);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop, input int rst_bit);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int j = 0; j < 10; j++) begin
      bus.rx = fr[j];
      for (int c = 0; c < 16; c++) begin
        if (j == rst_bit && c == 8) begin
          reset = 1'b1;
          bus.load_en = 1'b0;
          @(negedge clk);
          chk_reset_outs("midbyte_rst");
          reset = 1'b0;
        end else begin
          @(negedge clk);
        end
      end
    end
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.rx = 1'b1;
    bus.load_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 0);
    bus.load_en = 1'b1;
    repeat (2) @(negedge clk);
    check("load_busy", 32'(bus.busy), 1);
    send_byte(8'hA5, 1'b1, -1);
    send_byte(8'h3C, 1'b1, -1);
    send_byte(8'hFF, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    check("nom_nwr", 32'(wa.size()), 4);
    chk_wr(0, 16'd0, 8'hA5);
    chk_wr(1, 16'd1, 8'h3C);
    chk_wr(2, 16'd2, 8'hFF);
    chk_wr(3, 16'd3, 8'h00);
    check("nom_done", 32'(bus.done), 1);
    check("nom_busy", 32'(bus.busy), 0);
    send_byte(8'h77, 1'b1, -1);
    check("in_done_nwr", 32'(wa.size()), 4);
    check("done_hold", 32'(bus.done), 1);
    bus.load_en = 1'b0;
    repeat (2) @(negedge clk);
    check("done_release", 32'(bus.done), 0);
    send_byte(8'h66, 1'b1, -1);
    check("in_idle_nwr", 32'(wa.size()), 4);
    bus.load_en = 1'b1;
    repeat (2) @(negedge clk);
    bus.rx = 1'b0;
    repeat (5) @(negedge clk);
    bus.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_nwr", 32'(wa.size()), 4);
    send_byte(8'h81, 1'b1, -1);
    check("after_glitch_nwr", 32'(wa.size()), 5);
    chk_wr(4, 16'd0, 8'h81);
    send_byte(8'h55, 1'b0, -1);
    check("ferr_nwr", 32'(wa.size()), 5);
    check("ferr_set", 32'(bus.frame_err), 1);
    check("ferr_cnt", 32'(bus.ram_addr), 1);
    send_byte(8'h12, 1'b1, -1);
    chk_wr(5, 16'd1, 8'h12);
    check("ferr_sticky", 32'(bus.frame_err), 1);
    bus.load_en = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_ferr", 32'(bus.frame_err), 1);
    send_byte(8'h99, 1'b1, -1);
    check("abort_nwr", 32'(wa.size()), 6);
    bus.load_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rearm_ferr", 32'(bus.frame_err), 0);
    send_byte(8'h5A, 1'b1, -1);
    check("rearm_nwr", 32'(wa.size()), 7);
    chk_wr(6, 16'd0, 8'h5A);
    send_byte(8'hFF, 1'b1, 5);
    repeat (100) @(negedge clk);
    check("rst_nwr", 32'(wa.size()), 7);
    bus.load_en = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'hC3, 1'b1, -1);
    check("post_rst_nwr", 32'(wa.size()), 8);
    chk_wr(7, 16'd0, 8'hC3);
    check("single_cycle_we", 32'(dbl), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_ram_loader.md
UART_RAM_LOADER -- requirements
Module: uart_ram_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (115200 baud at 100 MHz); legal range 8..65535.
REQ-002 Parameter IMG_BYTES, default 65536, number of bytes in one image frame; legal range 1..2^ADDR_W.
REQ-003 Parameter ADDR_W, default 16, width of the RAM address.
REQ-004 Port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port rx, input, 1, asynchronous UART serial line; idle high; 8N1 framing.
REQ-007 Port load_en, input, 1, level request to load a frame (driven by the PC_RAM_ACT mode select).
REQ-008 Port ram_we, output, 1, one-cycle RAM write strobe.
REQ-009 Port ram_addr, output, ADDR_W, RAM write address, valid when ram_we=1.
REQ-010 Port ram_din, output, 8, RAM write data, valid when ram_we=1.
REQ-011 Port busy, output, 1, high while in LOAD state.
REQ-012 Port done, output, 1, high while in DONE state.
REQ-013 Port frame_err, output, 1, sticky flag: a stop bit was sampled low.
REQ-014 Port byte_cnt_led, output, 8, bits [ADDR_W-1:ADDR_W-8] of the write counter, for progress LEDs.

Function
REQ-015 rx shall pass through a 2-flop synchronizer (reset value 1); the RX FSM shall use only the synchronized value.
REQ-016 RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
- RX_IDLE to RX_START on synchronized rx=0.
REQ-017 In RX_START, after CLKS_PER_BIT/2 cycles, rx=0 shall go to RX_DATA; rx=1 is a glitch and shall return to RX_IDLE with no byte.
REQ-018 In RX_DATA, 8 bits shall be sampled LSB first, each exactly CLKS_PER_BIT cycles after the previous sample (mid-bit).
REQ-019 In RX_STOP, the stop bit shall be sampled CLKS_PER_BIT cycles after bit 7, then the FSM shall return to RX_IDLE.
- stop=1: byte valid.
- stop=0: byte discarded and frame_err set.
REQ-020 The RX FSM shall run in every loader state; bytes completed outside LOAD shall be discarded.
REQ-021 Loader FSM states: IDLE, LOAD, DONE.
- IDLE to LOAD when load_en=1; write counter cleared to 0 on entry.
REQ-022 In LOAD, each valid byte shall produce ram_we=1 for exactly one cycle, on the cycle after the stop-bit sample.
- ram_addr = current counter, ram_din = byte.
- Counter increments on the following edge.
REQ-023 When the write with address IMG_BYTES-1 completes, the FSM shall go to DONE on the next edge; no further writes in that frame.
REQ-024 DONE shall hold until load_en=0, then go to IDLE; the counter holds its final value in DONE and IDLE.
REQ-025 load_en=0 during LOAD shall abort to IDLE on the next edge: no further writes, done not asserted, counter holds.
- A byte whose strobe coincides with the abort edge is still written.
REQ-026 frame_err shall clear only on reset or on the IDLE to LOAD transition; setting takes priority if both occur in the same cycle.
REQ-027 Bit-timer and bit-index counters shall be sized for CLKS_PER_BIT and 8 bits respectively, with no wrap-around inside a frame.
- The write counter is ADDR_W+1 bits so IMG_BYTES=2^ADDR_W is representable.

Reset
REQ-028 On reset=1 at a clock edge:
- Loader to IDLE, RX FSM to RX_IDLE, all counters 0.
- Synchronizer flops 1.
- ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0, frame_err=0, byte_cnt_led=0.
REQ-029 Reset mid-byte or mid-frame shall abandon the partial byte and the frame; no write strobe on or after the reset edge.

Verification (CLKS_PER_BIT=16, IMG_BYTES=4, ADDR_W=16)
REQ-030 Nominal load:
- Stimulus: load_en=1; send bytes 0xA5, 0x3C, 0xFF, 0x00 at 16 cycles per bit.
- Response: four single-cycle strobes at addr 0..3 with those data; done=1 after the 4th; busy=0.
REQ-031 Glitch rejection:
- Stimulus: rx low for 5 cycles in RX_IDLE during LOAD.
- Response: no ram_we; the next real byte 0x81 is written at the current address.
REQ-032 Framing error:
- Stimulus: byte 0x55 sent with stop bit 0.
- Response: no write, frame_err=1, counter unchanged.
- Follow-up: next good byte 0x12 is written; frame_err stays 1 until the next IDLE to LOAD transition.
REQ-033 Abort:
- Stimulus: drop load_en after 2 bytes.
- Response: IDLE, done=0, no write for a 3rd byte.
- Follow-up: reassert load_en; the next byte is written at addr 0.
REQ-034 Reset mid-byte:
- Stimulus: reset pulsed during data bit 4.
- Response: all outputs at reset values, no strobe; the next full byte after re-arming is written at addr 0.
REQ-035 Bytes outside LOAD:
- Stimulus: bytes sent with load_en=0 and in DONE.
- Response: ram_we stays 0.
